adder: RTL and testbench
========================

Name: adder

Overview:
- Registered unsigned adder: samples two operands and presents their sum, truncated to operand width, on a registered output one clock later.
- Datapath leaf block, single clock domain, no handshake.
- Sum is modulo 2^WIDTH; carry-out is discarded.

Parameters:
- WIDTH, 2, bit width of each operand and of the sum output (must be ≥1).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RES_X  input  1  asynchronous reset, active-high; clears the output register immediately when asserted.
- NUM1  input  WIDTH  unsigned operand A.
- NUM2  input  WIDTH  unsigned operand B.
- SUM_OUT  output  WIDTH  registered sum (NUM1 + NUM2) mod 2^WIDTH.

Behaviour:
- Interface: one clock (CLK); reset RES_X is asynchronous and active-high.
- Storage: a single WIDTH-bit output register driving SUM_OUT directly. No combinational path from inputs to SUM_OUT.
- Reset:
  - RES_X rising forces SUM_OUT = 0 immediately, without waiting for a CLK edge.
  - While RES_X = 1, SUM_OUT holds 0 regardless of CLK, NUM1 or NUM2.
- Normal operation (RES_X = 0):
  - On each rising CLK edge, SUM_OUT <= (NUM1 + NUM2) mod 2^WIDTH.
  - The addition is unsigned and computed at WIDTH+1 bits; the MSB (carry) is dropped.
- Latency:
  - Exactly 1 cycle: operands stable before rising edge k appear on SUM_OUT after edge k.
  - SUM_OUT holds that value until the next rising edge.
  - Throughput is one sum per cycle; a new operand pair may be applied every cycle.
- Reset release:
  - The first CLK edge with RES_X = 0 loads the current sum.
  - RES_X deasserting between edges does not change SUM_OUT until the next edge.
- Reset mid-operation:
  - Asserting RES_X at any time, including the same edge an operand changes, clears SUM_OUT at once.
  - The in-flight sum is lost.
- Wrap-around examples (WIDTH = 2):
  - 3+1 = 0
  - 2+2 = 0
  - 3+3 = 2
  - 2+1 = 3
- Power-up before any reset: SUM_OUT is undefined. The bench must apply reset before checking values.
- Unknown operands (X/Z) sampled out of reset propagate as unknown; no sanitising is required.
- Synthesis: the output register uses an async-clear flop; no latches; the adder is purely combinational feeding the flop.

Test Plan:
- Reset: RES_X = 1 with NUM1 = 1, NUM2 = 1, CLK toggling -> SUM_OUT = 0 on every edge. Then RES_X = 0 -> SUM_OUT = 2 after the next rising edge.
- Basic add, 1-cycle latency: NUM1 = 0, NUM2 = 0 -> SUM_OUT = 0. Change to NUM1 = 1, NUM2 = 1 mid-cycle -> SUM_OUT stays 0 until the next rising edge, then reads 2.
- Max no-wrap: NUM1 = 2, NUM2 = 1 -> SUM_OUT = 3 one edge later.
- Wrap-around: NUM1 = 3, NUM2 = 1 -> SUM_OUT = 0. NUM1 = 3, NUM2 = 3 -> SUM_OUT = 2.
- Async reset mid-operation: with SUM_OUT = 3, assert RES_X = 1 between clock edges -> SUM_OUT = 0 immediately, before any CLK edge.
- Back-to-back: apply (1,1), (2,1), (3,1) on consecutive cycles -> SUM_OUT sequence 2, 3, 0, each lagging its inputs by one edge.

Source files
------------

// File: rtl/adder.sv
// Registered unsigned adder: SUM_OUT takes (NUM1 + NUM2) mod 2^WIDTH one clock
// after the operands are sampled; RES_X clears it asynchronously.
module adder #(
  parameter int WIDTH = 2
) (
  input  logic             CLK,
  input  logic             RES_X,
  input  logic [WIDTH-1:0] NUM1,
  input  logic [WIDTH-1:0] NUM2,
  output logic [WIDTH-1:0] SUM_OUT
);

  logic [WIDTH-1:0] sum_next;

  // WIDTH-bit addition: the carry out of the top bit is dropped, giving modulo 2^WIDTH
  always_comb begin
    sum_next = NUM1 + NUM2;
  end

  // Async-clear output register; the only state in the block
  always_ff @(posedge CLK or posedge RES_X) begin
    if (RES_X)
      SUM_OUT <= '0;
    else
      SUM_OUT <= sum_next;
  end

endmodule

// File: tb/tb_adder.sv
// Scoreboard bench for adder: a driver pushes expected sums into a queue,
// and a monitor pops and compares one sum after every rising clock edge.
module tb_adder;

  localparam int WIDTH = 2;
  localparam int MOD   = 1 << WIDTH;

  logic             CLK;
  logic             RES_X;
  logic [WIDTH-1:0] NUM1;
  logic [WIDTH-1:0] NUM2;
  logic [WIDTH-1:0] SUM_OUT;

  int compared   = 0;
  int mismatched = 0;
  bit started    = 1'b0;
  logic [WIDTH-1:0] exp_q[$];

  adder #(.WIDTH(WIDTH)) dut (
    .CLK    (CLK),
    .RES_X  (RES_X),
    .NUM1   (NUM1),
    .NUM2   (NUM2),
    .SUM_OUT(SUM_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: plain integer arithmetic reduced modulo 2^WIDTH
  function automatic logic [WIDTH-1:0] model(input int a, input int b);
    int s;
    s = (a + b) % MOD;
    return s[WIDTH-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expected);
    compared++;
    if (SUM_OUT !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: SUM_OUT=%0d expected=%0d at %0t", name, SUM_OUT, expected, $time);
    end
  endtask

  // Drive one operand pair between edges and record the sum it should produce
  task automatic applyStimulus(input int a, input int b);
    @(negedge CLK);
    NUM1 = a[WIDTH-1:0];
    NUM2 = b[WIDTH-1:0];
    exp_q.push_back(model(a, b));
  endtask

  // Monitor: one result per rising edge; a sum whose edge saw reset is lost, so 0 is expected
  initial begin
    logic             rst_at_edge;
    logic [WIDTH-1:0] e;
    forever begin
      @(posedge CLK);
      rst_at_edge = RES_X;
      #1;
      if (started && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (rst_at_edge) e = '0;
        checkOutput("scoreboard", e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RES_X = 1'b1;
    NUM1  = 1;
    NUM2  = 1;

    // Reset held with live operands: output must stay cleared on every edge
    repeat (3) begin
      @(posedge CLK);
      #1 checkOutput("reset_hold", '0);
    end

    // Release between edges: nothing changes until the next rising edge
    @(negedge CLK);
    RES_X = 1'b0;
    #1 checkOutput("release_no_change", '0);
    started = 1'b1;
    exp_q.push_back(model(1, 1));

    // Basic add, then a mid-cycle operand change that must not show before the edge
    applyStimulus(0, 0);
    applyStimulus(1, 1);
    #1 checkOutput("mid_cycle_hold", '0);

    // Max without wrap, then wrap-around cases
    applyStimulus(2, 1);
    applyStimulus(3, 1);
    applyStimulus(3, 3);
    applyStimulus(2, 2);
    applyStimulus(2, 1);

    // Async reset between edges while SUM_OUT holds 3
    @(posedge CLK);
    #2 checkOutput("pre_async", 2'd3);
    RES_X = 1'b1;
    #1 checkOutput("async_clear", '0);
    @(posedge CLK);
    #1 checkOutput("async_hold", '0);

    // Reset asserted in the same cycle an operand is applied: in-flight sum is lost
    @(negedge CLK);
    RES_X = 1'b0;
    applyStimulus(3, 2);
    #1 RES_X = 1'b1;
    @(posedge CLK);
    #2 RES_X = 1'b0;

    // Back-to-back operands after reset release
    applyStimulus(1, 1);
    applyStimulus(2, 1);
    applyStimulus(3, 1);

    // Randomized pairs, one per cycle
    for (int i = 0; i < 200; i++)
      applyStimulus($urandom_range(MOD - 1), $urandom_range(MOD - 1));

    // Drain with a bounded wait
    repeat (4) @(posedge CLK);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: %0d results left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
